// File: rtl/zynq_hb_req_sched_pkg.sv
// Shared types and defaults for the host-endpoint request scheduler.
package zynq_hb_req_sched_pkg;

  localparam int max_credits_gp     = 32;
  localparam int hb_credit_width_gp = $clog2(max_credits_gp + 1);

  typedef enum logic [1:0] {eRun, eFence, eDone} hb_req_sched_state_e;

endpackage

// File: rtl/zynq_hb_req_sched_if.sv
// Requester-side and endpoint-side handshake bundle of the request scheduler.
interface zynq_hb_req_sched_if #(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 32
);
  logic [num_req_p-1:0]                req_v;
  logic [num_req_p*packet_width_p-1:0] req_data;
  logic [num_req_p-1:0]                req_yumi;
  logic                                out_v;
  logic [packet_width_p-1:0]           out_data;
  logic                                out_ready;

  modport master (
    output req_v, req_data, out_ready,
    input  req_yumi, out_v, out_data
  );

  modport slave (
    input  req_v, req_data, out_ready,
    output req_yumi, out_v, out_data
  );
endinterface

// File: rtl/zynq_hb_req_sched_arb.sv
// Round-robin arbiter: grants the first requester after the last one served;
// the pointer moves only when the grant is consumed.
module zynq_hb_req_sched_arb #(
  parameter int width_p = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] reqs_i,
  output logic [width_p-1:0] grants_o,
  output logic               v_o,
  input  logic               yumi_i
);
  localparam int iw_lp = (width_p > 1) ? $clog2(width_p) : 1;

  logic [iw_lp-1:0] last_q;
  logic [iw_lp-1:0] sel;
  logic             found;
  int               idx;

  always_comb begin
    grants_o = '0;
    sel      = last_q;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= width_p; k++) begin
      idx = (int'(last_q) + k) % width_p;
      if (!found && reqs_i[iw_lp'(idx)]) begin
        found                   = 1'b1;
        grants_o[iw_lp'(idx)]   = 1'b1;
        sel                     = iw_lp'(idx);
      end
    end
  end

  assign v_o = found;

  // Starting from "last = top index" makes requester 0 the first in line.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)     last_q <= iw_lp'(width_p - 1);
    else if (yumi_i) last_q <= sel;
  end
endmodule

// File: rtl/zynq_hb_req_sched.sv
// Shares the host endpoint request port between requesters: round-robin grant,
// outstanding-credit gating and a drain-to-zero fence.
module zynq_hb_req_sched
  import zynq_hb_req_sched_pkg::*;
#(
  parameter int num_req_p      = 2,
  parameter int packet_width_p = 32,
  parameter int max_credits_p  = max_credits_gp,
  localparam int cw_lp         = $clog2(max_credits_p + 1)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  zynq_hb_req_sched_if.slave   bus,
  input  logic                 credit_return_i,
  input  logic                 fence_v_i,
  output logic                 fence_done_o,
  output logic [cw_lp-1:0]     credits_used_o,
  output logic                 credit_err_o
);
  hb_req_sched_state_e       state_q, state_n;
  logic [cw_lp-1:0]          credits_q, credits_n;
  logic                      err_q, err_n;
  logic                      issue_en;
  logic                      handshake;
  logic                      arb_v;
  logic [num_req_p-1:0]      grants;
  logic [packet_width_p-1:0] data_mux;

  assign issue_en = (state_q == eRun) & ~fence_v_i
                  & (credits_q < cw_lp'(max_credits_p)) & ~reset_i;

  zynq_hb_req_sched_arb #(.width_p(num_req_p)) u_arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reqs_i   (bus.req_v),
    .grants_o (grants),
    .v_o      (arb_v),
    .yumi_i   (handshake)
  );

  assign bus.out_v    = issue_en & arb_v;
  assign handshake    = bus.out_v & bus.out_ready;
  assign bus.req_yumi = grants & {num_req_p{handshake}};

  always_comb begin
    data_mux = '0;
    for (int i = 0; i < num_req_p; i++)
      data_mux |= {packet_width_p{grants[i]}} & bus.req_data[i*packet_width_p +: packet_width_p];
  end
  assign bus.out_data = data_mux;

  // A return with nothing outstanding is a protocol error: hold at zero and flag it.
  always_comb begin
    credits_n = credits_q;
    err_n     = err_q;
    if (handshake && !credit_return_i) begin
      credits_n = credits_q + cw_lp'(1);
    end else if (!handshake && credit_return_i) begin
      if (credits_q == '0) err_n     = 1'b1;
      else                 credits_n = credits_q - cw_lp'(1);
    end
  end

  always_comb begin
    state_n      = state_q;
    fence_done_o = 1'b0;
    unique case (state_q)
      eRun:    if (fence_v_i) state_n = eFence;
      eFence:  if (credits_n == '0) state_n = eDone;
      eDone: begin
        fence_done_o = 1'b1;
        state_n      = eRun;
      end
      default: state_n = eRun;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= eRun;
      credits_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_n;
      credits_q <= credits_n;
      err_q     <= err_n;
    end
  end

  assign credits_used_o = credits_q;
  assign credit_err_o   = err_q;

  a_yumi_onehot0: assert property (@(posedge clk_i) disable iff (reset_i)
    $onehot0(bus.req_yumi));
  a_credits_max: assert property (@(posedge clk_i) disable iff (reset_i)
    credits_q <= cw_lp'(max_credits_p));
endmodule

// File: tb/tb_zynq_hb_req_sched.sv
// Directed bench for zynq_hb_req_sched with a behavioural model and grant scoreboard.
module tb_zynq_hb_req_sched;
  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       credit_return_i;
  logic       fence_v_i;
  logic       fence_done_o;
  logic [5:0] credits_used_o;
  logic       credit_err_o;

  always #5 clk_i = ~clk_i;

  zynq_hb_req_sched_if #(.num_req_p(2), .packet_width_p(32)) ifc ();

  zynq_hb_req_sched #(.num_req_p(2), .packet_width_p(32), .max_credits_p(32)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .bus             (ifc),
    .credit_return_i (credit_return_i),
    .fence_v_i       (fence_v_i),
    .fence_done_o    (fence_done_o),
    .credits_used_o  (credits_used_o),
    .credit_err_o    (credit_err_o)
  );

  typedef struct {
    int          idx;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   m_last, m_cred, m_state;
  logic m_err;
  int   done_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_last  = 1;
    m_cred  = 0;
    m_state = 0;
    m_err   = 1'b0;
    sb.delete();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_v"},   64'(ifc.out_v),        64'd0);
    chk({tag, "_yumi"},    64'(ifc.req_yumi),     64'd0);
    chk({tag, "_credits"}, 64'(credits_used_o),   64'd0);
    chk({tag, "_done"},    64'(fence_done_o),     64'd0);
    chk({tag, "_err"},     64'(credit_err_o),     64'd0);
  endtask

  // One clock cycle: drive at negedge, predict and check at negedge+1, advance model at posedge.
  task automatic step(input logic [1:0] v, input logic rdy, input logic ret, input logic fen);
    int          exp_g, j, obs_g;
    logic        en, exp_v, hs;
    logic [1:0]  exp_y;
    exp_t        item;
    ifc.req_v       = v;
    ifc.out_ready   = rdy;
    credit_return_i = ret;
    fence_v_i       = fen;
    ifc.req_data    = {$urandom(), $urandom()};
    #1;
    en    = (m_state == 0) && !fen && (m_cred < 32);
    exp_g = -1;
    for (int k = 1; k <= 2; k++) begin
      j = (m_last + k) % 2;
      if (exp_g < 0 && v[1'(j)]) exp_g = j;
    end
    exp_v = en && (exp_g >= 0);
    hs    = exp_v && rdy;
    exp_y = hs ? (2'b01 << exp_g) : 2'b00;
    if (hs) begin
      item.idx  = exp_g;
      item.data = (exp_g == 1) ? ifc.req_data[63:32] : ifc.req_data[31:0];
      sb.push_back(item);
    end
    chk("out_v",      64'(ifc.out_v),      64'(exp_v));
    chk("req_yumi",   64'(ifc.req_yumi),   64'(exp_y));
    chk("credits",    64'(credits_used_o), 64'(m_cred));
    chk("fence_done", 64'(fence_done_o),   64'(m_state == 2));
    chk("credit_err", 64'(credit_err_o),   64'(m_err));
    if (fence_done_o) done_cnt++;
    if (ifc.out_v && ifc.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_handshake", 64'd1, 64'd0);
      end else begin
        item  = sb.pop_front();
        obs_g = ifc.req_yumi[1] ? 1 : 0;
        chk("grant_idx", 64'(obs_g),        64'(item.idx));
        chk("out_data",  64'(ifc.out_data), 64'(item.data));
      end
    end
    if (sb.size() != 0) begin
      chk("missing_handshake", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(posedge clk_i);
    if (hs) m_last = exp_g;
    if (hs && !ret) m_cred++;
    else if (ret && !hs) begin
      if (m_cred == 0) m_err = 1'b1;
      else             m_cred--;
    end
    case (m_state)
      0:       if (fen) m_state = 1;
      1:       if (m_cred == 0) m_state = 2;
      default: m_state = 0;
    endcase
    @(negedge clk_i);
  endtask

  task automatic drain();
    while (m_cred > 0) step(2'b00, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic issue(input int n);
    repeat (n) step(2'b11, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset_i         = 1'b1;
    ifc.req_v       = 2'b11;
    ifc.req_data    = '0;
    ifc.out_ready   = 1'b1;
    credit_return_i = 1'b0;
    fence_v_i       = 1'b0;
    done_cnt        = 0;
    model_reset();
    @(negedge clk_i); #1;
    chk_reset("reset");
    @(negedge clk_i);
    reset_i = 1'b0;

    // Saturate credits with both requesters valid, then trickle one credit back.
    issue(32);
    chk("t1_cred_max", 64'(credits_used_o), 64'd32);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // Lone requester 1 with a toggling ready, then requester 0 joins.
    for (int i = 0; i < 6; i++) step(2'b10, 1'(i % 2 == 0), 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    drain();

    // Fence with five outstanding credits returned over eight cycles.
    issue(5);
    done_cnt = 0;
    step(2'b11, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(2'b11, 1'b1, 1'((8'b01101101 >> i) & 1), 1'b0);
    chk("t3_done_pulses", 64'(done_cnt), 64'd1);
    issue(2);
    drain();

    // Fence with nothing outstanding.
    done_cnt = 0;
    step(2'b00, 1'b0, 1'b0, 1'b1);
    repeat (3) step(2'b00, 1'b0, 1'b0, 1'b0);
    chk("t4_done_pulses", 64'(done_cnt), 64'd1);

    // Simultaneous issue and return, then an underflowing return.
    issue(7);
    step(2'b11, 1'b1, 1'b1, 1'b0);
    chk("t5_cred_hold", 64'(credits_used_o), 64'd7);
    drain();
    step(2'b00, 1'b0, 1'b1, 1'b0);
    repeat (3) step(2'b01, 1'b1, 1'b0, 1'b0);
    chk("t5_err_sticky", 64'(credit_err_o), 64'd1);
    drain();

    // Asynchronous reset in the middle of a fence with twelve outstanding.
    issue(12);
    step(2'b11, 1'b1, 1'b0, 1'b1);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    ifc.req_v     = 2'b11;
    ifc.out_ready = 1'b1;
    #2 reset_i = 1'b1;
    #1 chk_reset("async_reset");
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    issue(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
